bram_port_arb: RTL
==================

# bram_port_arb

Round-robin arbiter that shares the single external BRAM port (BRAM_ADDR/BRAM_WRDATA/BRAM_WE/BRAM_RDDATA) between NUM_REQ requesters, for example the PE controller's load/write-back sequencer and a host-side loader. It grants the port for bursts of back-to-back single-cycle accesses. It tags returned read data with the owner index. With the timeout option compiled in, it caps burst length so that no requester can starve the others.

## Interface
- NUM_REQ, 2: number of requesters (2..8)
- ADDR_W, 32: BRAM byte-address width
- DATA_W, 32: BRAM data width
- MAX_BURST, 64: beat cap per grant; used only when BRAM_ARB_TIMEOUT_EN is defined
- aclk  in  1  sole clock; all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request; held high for the whole burst
- last  in  NUM_REQ  marks the final beat of a burst
- addr  in  NUM_REQ*ADDR_W  flattened; slice i = requester i address
- wrdata  in  NUM_REQ*DATA_W  flattened write data
- we  in  NUM_REQ*4  flattened byte write enables
- gnt  out  NUM_REQ  one-hot grant, registered
- rdvalid  out  1  read data valid
- rdid  out  $clog2(NUM_REQ)  owner index of the returned read
- rddata  out  DATA_W  equals BRAM_RDDATA
- busy  out  1  high while the arbiter is in the BUSY state
- BRAM_ADDR  out  ADDR_W  muxed address
- BRAM_WRDATA  out  DATA_W  muxed write data
- BRAM_WE  out  4  muxed byte enables
- BRAM_RDDATA  in  DATA_W  BRAM read data, 1-cycle latency

## Operation
- States: IDLE and BUSY. Registers: owner index, round-robin pointer ptr, beat counter bcnt.
- **IDLE:**
  - If any req is high, the winner is the first requester at or after ptr, scanning with modulo wrap.
  - At the next edge: gnt[winner]=1, owner=winner, bcnt=0, state goes to BUSY.
- **BUSY:** a beat is any cycle with gnt[owner]&&req[owner]. The BRAM outputs carry slice [owner] of addr, wrdata and we. bcnt increments on each beat.
- **Release:** at the edge ending a cycle that matches any of the following, gnt goes to 0, ptr=(owner+1)%NUM_REQ, and state goes to IDLE.
  - (a) A beat with last[owner]=1.
  - (b) req[owner]=0. No beat is issued in that cycle.
  - (c) Timeout: a beat with bcnt==MAX_BURST-1.
- **Muxing outside a beat:** when not in a beat (IDLE, or a release cycle of type b), BRAM_WE=0, BRAM_ADDR=0 and BRAM_WRDATA=0. No access ever reaches the BRAM without a grant.
- **Read tagging:** a beat with we==0 is a read. In the next cycle rdvalid=1 and rdid=owner of that beat. This holds even if the grant has since dropped.
- **Ignored inputs:** last on a non-owner is ignored. last while req is low is ignored.
- **Simultaneous requests:** the round-robin rule alone resolves them. The previous owner becomes lowest priority.
- **Counter width:** bcnt is $clog2(MAX_BURST) bits wide and never wraps within a grant.

## Timing
- Reset values: gnt=0, rdvalid=0, rdid=0, busy=0, BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0, state=IDLE, ptr=0, bcnt=0.
- Grant latency: req rises in cycle N, so gnt is asserted in cycle N+1. The first beat can occur in N+1.
- Hand-over: release takes effect in cycle M (gnt=0). The next grant appears no earlier than M+1, giving exactly one dead cycle between owners.
- Throughput: one beat per cycle while granted.
- Read data: rdvalid, rdid and rddata arrive one cycle after the read beat.
- Reset mid-burst: asserting areset immediately clears gnt, BRAM_WE, rdvalid and all state. Any in-flight read is dropped with no rdvalid.

## Configuration
- BRAM_ARB_TIMEOUT_EN defined: release condition (c) is active, so a grant lasts at most MAX_BURST beats. A requester still holding req re-arbitrates and is now lowest priority.
- BRAM_ARB_TIMEOUT_EN undefined: (c) is absent and bcnt is not instantiated. A grant lasts until last or until req drops. MAX_BURST is ignored.

## Structure
- Package bram_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_BUSY);
  - the width constants BYTE_EN_W=4 and the default DATA_W;
  - a function computing the index width $clog2(NUM_REQ), with a minimum of 1.
- Sub-module rr_pick: a purely combinational round-robin picker. Inputs are req and ptr; outputs are winner index and any_req. It is instantiated once.

## Test plan
- Single read burst:
  - Stimulus: after reset, req[0]=1 for 4 beats with addr 0x0,0x4,0x8,0xC and we=0, last on the 4th beat.
  - Response: gnt[0] the cycle after req; BRAM_ADDR follows the 4 addresses; 4 rdvalid pulses with rdid=0, each one cycle after its beat; gnt drops after the last beat.
- Contention and rotation:
  - Stimulus: req[0] and req[1] rise in the same cycle, with ptr=0 after reset.
  - Response: requester 0 is granted first; after its last beat there is one dead cycle, then gnt[1]. A re-request from 0 is served only after 1 releases.
- Write beats:
  - Stimulus: requester 1 writes 0xDEADBEEF with we=0xF to 0x100.
  - Response: BRAM_WE=0xF, BRAM_WRDATA=0xDEADBEEF, BRAM_ADDR=0x100 in the beat cycle; rdvalid stays 0; BRAM_WE=0 in every cycle without a grant.
- Early release:
  - Stimulus: the owner drops req without last after 2 beats.
  - Response: no beat is issued in the drop cycle; gnt goes to 0 at the next edge; ptr advances.
- Timeout:
  - Stimulus: BRAM_ARB_TIMEOUT_EN defined, MAX_BURST=8, requester 0 holds req with no last while requester 1 is waiting.
  - Response: gnt[0] drops after exactly 8 beats, then gnt[1]. With the macro undefined, gnt[0] persists for 100 or more beats.
- Async reset mid-burst:
  - Stimulus: areset pulses during beat 3 of a read burst.
  - Response: gnt, BRAM_WE and rdvalid are 0 immediately; no rdvalid for the pending read; after release of reset, requester 0 wins over 1 when both request.

Source files
------------

// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arb_pkg
//  Description : Shared types, constants and helpers for the BRAM port
//                arbiter (state encoding, byte-enable width, index width).
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

    // Arbiter states, explicit 1-bit encoding
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int BYTE_EN_W  = 4;
    localparam int DEF_DATA_W = 32;

    // Index width for n items; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arb_if
//  Description : Bundle of requester-side and BRAM-side signals of the
//                arbiter. slave = arbiter view, master = requesters + BRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bram_arb_if
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int ID_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           last;
    logic [NUM_REQ*ADDR_W-1:0]    addr;
    logic [NUM_REQ*DATA_W-1:0]    wrdata;
    logic [NUM_REQ*BYTE_EN_W-1:0] we;
    logic [NUM_REQ-1:0]           gnt;
    logic                         rdvalid;
    logic [ID_W-1:0]              rdid;
    logic [DATA_W-1:0]            rddata;
    logic                         busy;
    logic [ADDR_W-1:0]            BRAM_ADDR;
    logic [DATA_W-1:0]            BRAM_WRDATA;
    logic [BYTE_EN_W-1:0]         BRAM_WE;
    logic [DATA_W-1:0]            BRAM_RDDATA;

    modport slave (
        input  req, last, addr, wrdata, we, BRAM_RDDATA,
        output gnt, rdvalid, rdid, rddata, busy, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
    );

    modport master (
        output req, last, addr, wrdata, we, BRAM_RDDATA,
        input  gnt, rdvalid, rdid, rddata, busy, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
    );

endinterface
`default_nettype wire

// File: rtl/bram_port_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first active
//                request at or after ptr, wrapping modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    logic w_found;

    // (base + off) mod NUM_REQ, with base < NUM_REQ and off < NUM_REQ
    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan from ptr upward; the first hit wins
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[wrap_idx(int'(ptr), k)]) begin
                winner  = wrap_idx(int'(ptr), k);
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/bram_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bram_port_arb
//  Description : Round-robin arbiter sharing one BRAM port among NUM_REQ
//                requesters. Grants bursts of single-cycle beats and tags
//                returned read data with the owner index.
//                Optional macro BRAM_ARB_TIMEOUT_EN caps a grant at
//                MAX_BURST beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arb
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 64
)(
    input  logic       aclk,
    input  logic       areset,
    bram_arb_if.slave  bus
);

    localparam int ID_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_cfg_check
        $error("bram_port_arb: unsupported NUM_REQ or MAX_BURST");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_owner_inc;
    logic               w_any_req;
    logic               w_beat;
    logic               w_is_read;
    logic               w_grant;
    logic               w_release;
    logic               w_timeout;
    logic               r_rdvalid;
    logic [ID_W-1:0]    r_rdid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (bus.req),
        .ptr     (r_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_beat      = (r_state == ARB_BUSY) && r_gnt[r_owner] && bus.req[r_owner];
    assign w_is_read   = (bus.we[r_owner*BYTE_EN_W +: BYTE_EN_W] == '0);
    assign w_owner_inc = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_w(MAX_BURST);
    logic [CNT_W-1:0] r_bcnt;

    assign w_timeout = w_beat && (r_bcnt == CNT_W'(MAX_BURST - 1));

    // Beat counter: cleared on grant, held on the releasing beat so it never wraps
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_bcnt <= '0;
        else if (w_grant)
            r_bcnt <= '0;
        else if (w_beat && !w_release)
            r_bcnt <= r_bcnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            r_state <= ARB_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state plus grant / release strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!bus.req[r_owner] || (w_beat && bus.last[r_owner]) || w_timeout) begin
                    w_release   = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
        endcase
    end

    // Grant, owner and round-robin pointer; releasing owner becomes lowest priority
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_grant) begin
            r_gnt   <= NUM_REQ'(1) << w_winner;
            r_owner <= w_winner;
        end else if (w_release) begin
            r_gnt   <= '0;
            r_ptr   <= w_owner_inc;
        end
    end

    // Read tag follows the BRAM's one-cycle read latency
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rdvalid <= 1'b0;
            r_rdid    <= '0;
        end else begin
            r_rdvalid <= w_beat && w_is_read;
            r_rdid    <= r_owner;
        end
    end

    // BRAM port mux: only a live beat reaches the BRAM, otherwise all zero
    always_comb begin
        bus.BRAM_ADDR   = '0;
        bus.BRAM_WRDATA = '0;
        bus.BRAM_WE     = '0;
        if (w_beat) begin
            bus.BRAM_ADDR   = bus.addr[r_owner*ADDR_W +: ADDR_W];
            bus.BRAM_WRDATA = bus.wrdata[r_owner*DATA_W +: DATA_W];
            bus.BRAM_WE     = bus.we[r_owner*BYTE_EN_W +: BYTE_EN_W];
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.rdvalid = r_rdvalid;
    assign bus.rdid    = r_rdid;
    assign bus.rddata  = bus.BRAM_RDDATA;
    assign bus.busy    = (r_state == ARB_BUSY);

endmodule
`default_nettype wire
